// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer constants, load states and pixel type
package fb_pkg;

   // Display geometry shared by the load controller, VGA timing and video memory
   localparam int FB_H_RES  = 640;
   localparam int FB_V_RES  = 480;
   localparam int FB_ADDR_W = 19;
   localparam int FB_X_W    = 10;
   localparam int FB_Y_W    = 9;

   localparam logic [7:0] FB_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_R,
      ST_GET_G,
      ST_GET_B,
      ST_PEND
   } fb_load_state_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

endpackage

// File: rtl/fb_addr_counter.sv
// rtl/fb_addr_counter.sv - raster x/y counter with clear, increment and last-pixel flag
module fb_addr_counter
   import fb_pkg::*;
#(
   parameter int H_RES = FB_H_RES,
   parameter int V_RES = FB_V_RES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   output logic [FB_X_W-1:0] x,
   output logic [FB_Y_W-1:0] y,
   output logic              last
);

   localparam logic [FB_X_W-1:0] X_MAX = FB_X_W'(H_RES - 1);
   localparam logic [FB_Y_W-1:0] Y_MAX = FB_Y_W'(V_RES - 1);

   assign last = (x == X_MAX) && (y == Y_MAX);

   // Advance in raster order; the position parks on the last pixel instead of wrapping
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         x <= '0;
         y <= '0;
      end else if (inc && !last) begin
         if (x == X_MAX) begin
            x <= '0;
            y <= y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fb_load_ctrl.sv
// rtl/fb_load_ctrl.sv - assembles UART bytes into RGB pixels and writes them to video memory
module fb_load_ctrl
   import fb_pkg::*;
#(
   parameter int         H_RES      = FB_H_RES,
   parameter int         V_RES      = FB_V_RES,
   parameter logic [7:0] SYNC_BYTE  = FB_SYNC_BYTE,
   parameter int         BLANK_ONLY = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   output logic                 rx_ready,
   input  logic                 disp_valid,
   input  logic                 abort,
   output logic                 we,
   output logic [FB_ADDR_W-1:0] waddr,
   output logic [23:0]          wdata,
   output logic                 busy,
   output logic                 frame_done
);

   fb_load_state_t    state, state_nxt;
   rgb_t              pixel;
   logic [FB_X_W-1:0] x;
   logic [FB_Y_W-1:0] y;
   logic              last;
   logic              accept;
   logic              sync_hit;
   logic              grant;

   // PEND is the only state that cannot take a byte; upstream holds it meanwhile
   assign rx_ready = (state != ST_PEND);
   assign busy     = (state != ST_IDLE);
   assign accept   = rx_valid && rx_ready;
   assign sync_hit = (state == ST_IDLE) && accept && (rx_data == SYNC_BYTE) && !abort;
   // Abort suppresses the pending write so nothing is registered from that edge on
   assign grant    = (state == ST_PEND) && ((BLANK_ONLY == 0) || !disp_valid) && !abort;

   fb_addr_counter #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_addr_counter (
      .clk  (clk),
      .rst  (rst),
      .clr  (sync_hit),
      .inc  (grant),
      .x    (x),
      .y    (y),
      .last (last)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: byte-driven through R/G/B, grant-driven out of PEND, abort overrides all
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (sync_hit) state_nxt = ST_GET_R;
         ST_GET_R: if (accept)   state_nxt = ST_GET_G;
         ST_GET_G: if (accept)   state_nxt = ST_GET_B;
         ST_GET_B: if (accept)   state_nxt = ST_PEND;
         ST_PEND:  if (grant)    state_nxt = last ? ST_IDLE : ST_GET_R;
         default:                state_nxt = ST_IDLE;
      endcase
      if (abort) begin
         state_nxt = ST_IDLE;
      end
   end

   // Latch colour components as they arrive; an aborted byte is dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         pixel <= '0;
      end else if (accept && !abort) begin
         case (state)
            ST_GET_R: pixel.r <= rx_data;
            ST_GET_G: pixel.g <= rx_data;
            ST_GET_B: pixel.b <= rx_data;
            default:  pixel   <= pixel;
         endcase
      end
   end

   // Registered write port; frame_done marks the write of the final raster position
   always_ff @(posedge clk) begin
      if (rst) begin
         we         <= 1'b0;
         waddr      <= '0;
         wdata      <= '0;
         frame_done <= 1'b0;
      end else begin
         we         <= grant;
         frame_done <= grant && last;
         if (grant) begin
            waddr <= {y, x};
            wdata <= pixel;
         end
      end
   end

endmodule

// File: tb/tb_fb_load_ctrl.sv
// tb/tb_fb_load_ctrl.sv - scoreboard bench for the framebuffer load controller
module tb_fb_load_ctrl;
   import fb_pkg::*;

   localparam int HR = 4;
   localparam int VR = 2;

   logic        clk = 1'b0;
   logic        rst, rx_valid, disp_valid, abort;
   logic [7:0]  rx_data;
   logic        rx_ready, we, busy, frame_done;
   logic [18:0] waddr;
   logic [23:0] wdata;
   logic        f_rx_ready, f_we, f_busy, f_frame_done;
   logic [18:0] f_waddr;
   logic [23:0] f_wdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_we_cyc;
   int f_we_cnt;
   logic [43:0] sb_q[$];
   logic [43:0] mon_exp;

   fb_load_ctrl #(.H_RES(HR), .V_RES(VR), .SYNC_BYTE(8'hA5), .BLANK_ONLY(1)) u_dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .disp_valid(disp_valid), .abort(abort), .we(we), .waddr(waddr), .wdata(wdata),
      .busy(busy), .frame_done(frame_done)
   );

   fb_load_ctrl #(.H_RES(HR), .V_RES(VR), .SYNC_BYTE(8'hA5), .BLANK_ONLY(0)) u_free (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(f_rx_ready),
      .disp_valid(disp_valid), .abort(abort), .we(f_we), .waddr(f_waddr), .wdata(f_wdata),
      .busy(f_busy), .frame_done(f_frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!rst) begin
         if (we) begin
            last_we_cyc = cyc;
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_we got waddr=%0h wdata=%0h fd=%0b expected no write",
                        waddr, wdata, frame_done);
            end else begin
               mon_exp = sb_q.pop_front();
               if ({waddr, wdata, frame_done} !== mon_exp) begin
                  errors++;
                  $display("FAIL sb_write got waddr=%0h wdata=%0h fd=%0b expected waddr=%0h wdata=%0h fd=%0b",
                           waddr, wdata, frame_done, mon_exp[43:25], mon_exp[24:1], mon_exp[0]);
               end
            end
         end else if (frame_done) begin
            checks++;
            errors++;
            $display("FAIL frame_done_without_we got frame_done=1 expected 0");
         end
         if (f_we) f_we_cnt++;
      end
   end

   task automatic push_exp(input logic [18:0] a, input logic [23:0] d, input logic fd);
      sb_q.push_back({a, d, fd});
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      while (!rx_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got rx_ready=0 expected 1 byte=%0h", b);
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      send_byte(r);
      send_byte(g);
      send_byte(b);
   endtask

   task automatic drain(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_sb_empty(input string name);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL %s pending writes got %0d expected 0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      rx_valid = 1'b0;
      abort    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({we, waddr, wdata, busy, frame_done, rx_ready} !== {1'b0, 19'd0, 24'd0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_values got we=%0b waddr=%0h wdata=%0h busy=%0b fd=%0b rx_ready=%0b expected 0 0 0 0 0 1",
                  we, waddr, wdata, busy, frame_done, rx_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int t0, low_cnt;
      do_reset();
      disp_valid  = 1'b0;
      last_we_cyc = -1;
      push_exp(19'd0, 24'h112233, 1'b0);
      send_byte(8'hA5);
      t0 = cyc;
      send_pixel(8'h11, 8'h22, 8'h33);
      low_cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (!rx_ready) low_cnt++;
      end
      checks++;
      if (last_we_cyc !== t0 + 4) begin
         errors++;
         $display("FAIL basic_latency got %0d cycles expected 4", last_we_cyc - t0);
      end
      checks++;
      if (low_cnt !== 1) begin
         errors++;
         $display("FAIL basic_rx_ready_low got %0d cycles expected 1", low_cnt);
      end
      check_sb_empty("basic_sb");
   endtask

   task automatic test_preamble();
      do_reset();
      disp_valid = 1'b0;
      send_byte(8'h00);
      send_byte(8'hFF);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL preamble_busy_before got %0b expected 0", busy);
      end
      push_exp(19'd0, 24'h010203, 1'b0);
      send_byte(8'hA5);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL preamble_busy_after got %0b expected 1", busy);
      end
      send_pixel(8'h01, 8'h02, 8'h03);
      drain(3);
      check_sb_empty("preamble_sb");
   endtask

   task automatic test_blanking();
      int viol;
      do_reset();
      disp_valid = 1'b1;
      f_we_cnt   = 0;
      push_exp(19'd0, 24'hC0FFEE, 1'b0);
      send_byte(8'hA5);
      send_pixel(8'hC0, 8'hFF, 8'hEE);
      viol = 0;
      repeat (50) begin
         @(negedge clk);
         if (rx_ready || we) viol++;
      end
      checks++;
      if (viol !== 0) begin
         errors++;
         $display("FAIL blank_hold got %0d cycles with rx_ready or we high expected 0", viol);
      end
      checks++;
      if (f_we_cnt !== 1 || f_waddr !== 19'd0 || f_wdata !== 24'hC0FFEE) begin
         errors++;
         $display("FAIL free_run_write got count=%0d waddr=%0h wdata=%0h expected 1 0 c0ffee",
                  f_we_cnt, f_waddr, f_wdata);
      end
      @(posedge clk);
      #1;
      disp_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (we !== 1'b0) begin
         errors++;
         $display("FAIL blank_we_early got %0b expected 0", we);
      end
      @(negedge clk);
      checks++;
      if (we !== 1'b1) begin
         errors++;
         $display("FAIL blank_we_release got %0b expected 1", we);
      end
      drain(2);
      check_sb_empty("blank_sb");
   endtask

   task automatic test_frame_wrap();
      logic [7:0] g;
      do_reset();
      disp_valid = 1'b0;
      send_byte(8'hA5);
      for (int i = 0; i < 8; i++) begin
         g = (i == 2) ? 8'hA5 : 8'(8'h40 + i);
         push_exp(19'(((i / 4) << 10) | (i % 4)), {8'(i), g, 8'(8'h80 + i)}, (i == 7));
         send_pixel(8'(i), g, 8'(8'h80 + i));
      end
      drain(3);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL frame_busy_after got %0b expected 0", busy);
      end
      check_sb_empty("frame_sb");
      send_pixel(8'h10, 8'h20, 8'h30);
      drain(3);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL frame_extra_busy got %0b expected 0", busy);
      end
   endtask

   task automatic test_abort();
      do_reset();
      disp_valid = 1'b1;
      send_byte(8'hA5);
      send_pixel(8'h01, 8'h02, 8'h03);
      drain(5);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || f_busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle got busy=%0b f_busy=%0b expected 0 0", busy, f_busy);
      end
      drain(5);
      disp_valid = 1'b0;
      push_exp(19'd0, 24'h0A0B0C, 1'b0);
      send_byte(8'hA5);
      send_pixel(8'h0A, 8'h0B, 8'h0C);
      drain(3);
      check_sb_empty("abort_sb");
   endtask

   task automatic test_reset_mid();
      do_reset();
      disp_valid = 1'b0;
      push_exp(19'd0, 24'h111111, 1'b0);
      push_exp(19'd1, 24'h222222, 1'b0);
      send_byte(8'hA5);
      send_pixel(8'h11, 8'h11, 8'h11);
      send_pixel(8'h22, 8'h22, 8'h22);
      send_byte(8'h33);
      send_byte(8'h34);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({we, waddr, wdata, busy, frame_done, rx_ready} !== {1'b0, 19'd0, 24'd0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL midreset_values got we=%0b waddr=%0h wdata=%0h busy=%0b fd=%0b rx_ready=%0b expected 0 0 0 0 0 1",
                  we, waddr, wdata, busy, frame_done, rx_ready);
      end
      rst = 1'b0;
      check_sb_empty("midreset_pre_sb");
      push_exp(19'd0, 24'h445566, 1'b0);
      send_byte(8'hA5);
      send_pixel(8'h44, 8'h55, 8'h66);
      drain(3);
      check_sb_empty("midreset_sb");
   endtask

   initial begin
      rst        = 1'b1;
      rx_valid   = 1'b0;
      rx_data    = 8'h00;
      disp_valid = 1'b0;
      abort      = 1'b0;
      f_we_cnt   = 0;
      last_we_cyc = -1;
      test_reset();
      test_basic();
      test_preamble();
      test_blanking();
      test_frame_wrap();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fb_load_ctrl.md
# fb_load_ctrl

Framebuffer load controller: it takes the UART receiver's byte stream, assembles 24-bit RGB pixels and writes them into the video memory's write port in raster order. It sits between the UART receiver and the video memory, alongside the VGA timing controller. It optionally defers writes to blanking intervals so that scanout reads never collide with writes. One frame is loaded per sync byte; `frame_done` can drive an LED or the seven-segment status display.

## Interface

Parameters:
- `H_RES`, 640, active pixels per line.
- `V_RES`, 480, active lines per frame.
- `SYNC_BYTE`, 8'hA5, frame-start marker.
- `BLANK_ONLY`, 1: when 1, writes are issued only while `disp_valid`=0; when 0, writes are issued whenever a pixel is ready.

Ports:
- `clk` in 1: single clock, shared with the VGA pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: `rx_data` is valid this cycle.
- `rx_ready` out 1: the block accepts the byte this cycle.
- `disp_valid` in 1: VGA active-region flag (same signal as `VGA_BLANK_N`).
- `abort` in 1: synchronous cancel of a frame load in progress.
- `we` out 1: video memory write strobe, one cycle per write.
- `waddr` out 19: write address, {y[8:0], x[9:0]}.
- `wdata` out 24: pixel value, {R,G,B}.
- `busy` out 1: a frame load is in progress (state is not IDLE).
- `frame_done` out 1: one-cycle pulse after the last pixel is written.

## Operation

- A byte is accepted on any cycle where `rx_valid` and `rx_ready` are both 1.
- State machine states: IDLE, GET_R, GET_G, GET_B, PEND.
- IDLE:
  - `rx_ready`=1.
  - An accepted byte equal to `SYNC_BYTE` clears x and y to 0 and moves to GET_R.
  - Any other byte is discarded.
- GET_R, GET_G, GET_B:
  - `rx_ready`=1.
  - The accepted byte is latched into the R, G or B field of the pixel register, then the state advances.
  - GET_B advances to PEND.
- PEND:
  - `rx_ready`=0.
  - Grant = `!BLANK_ONLY || !disp_valid`.
  - On grant: register `we`=1, `waddr`={y,x} and `wdata`=pixel for the next cycle, then advance the counters.
  - After a grant, go to GET_R, or to IDLE if this was the last pixel.
- Counter rules:
  - Incrementing x: if x==H_RES-1, set x=0 and increment y.
  - Last pixel: x==H_RES-1 and y==V_RES-1. The write proceeds, the next state is IDLE, and `frame_done` pulses in the same cycle as that final `we`.
- Stream constraints:
  - No wrap past the last pixel.
  - Bytes after the frame are treated as IDLE traffic, discarded until the next `SYNC_BYTE`.
  - Data bytes equal to `SYNC_BYTE` inside a frame are pixel data; they are not a resync.
- `abort`:
  - Forces IDLE on the next edge from any state.
  - A pending pixel is dropped and no `we` is issued from that edge on.
  - A `we` already registered in the abort cycle still completes.
  - x and y are held; they are cleared only on the next sync byte.
  - If `abort` and a byte acceptance coincide, `abort` wins and the byte is consumed and discarded.

## Timing

- Reset values:
  - state IDLE, x=0, y=0, pixel=0.
  - `we`=0, `waddr`=0, `wdata`=0.
  - `busy`=0, `frame_done`=0.
  - `rx_ready`=1, since it is combinational from state.
- `rx_ready` and `busy` are combinational from state. `we`, `waddr`, `wdata` and `frame_done` are registered.
- Latency: B byte accepted at edge N gives PEND from N. If grant holds in the cycle after N, `we`=1 in the cycle after edge N+1.
- Minimum pixel period is 4 cycles (R, G, B, PEND). Sustained stream rate is bounded by this, not by UART.
- With `BLANK_ONLY`=1, PEND persists for the whole active line. Backpressure via `rx_ready`=0 is mandatory; the upstream receiver holds the byte.
- `rst` mid-frame: everything returns to reset values on the next edge, with no `we` and no `frame_done`.
- `we` is never asserted in a cycle where the registered grant was false.

## Structure

- Shared package `fb_pkg`:
  - `H_RES`/`V_RES` defaults.
  - `FB_ADDR_W`=19.
  - `SYNC_BYTE`.
  - State enum `fb_load_state_t`.
  - `rgb_t` packed struct {r,g,b}.
- `vga_ctrl` and the video memory use the same resolution constants from this package.
- One natural sub-module, `fb_addr_counter`: the x/y raster counter with clear, increment and last-pixel flag.
- Everything else is flat in `fb_load_ctrl`.

## Test plan

- **Basic pixel:** `BLANK_ONLY`=0, bytes A5,11,22,33 back-to-back → one `we`, `waddr`=0, `wdata`=24'h112233, exactly 4 cycles after the A5 was accepted; `rx_ready` low for 1 cycle.
- **Preamble discard:** bytes 00,FF,A5,01,02,03 → the first two are discarded, a single write of 24'h010203 lands at address 0, and `busy` rises after A5.
- **Blanking gate:** `BLANK_ONLY`=1, `disp_valid`=1 held for 50 cycles after pixel assembly → `rx_ready`=0 and `we`=0 throughout; `we` occurs the cycle after `disp_valid` falls.
- **Line and frame wrap:** `H_RES`=4, `V_RES`=2, sync plus 8 pixels → addresses 0,1,2,3,1024,1025,1026,1027; `frame_done` is high with the last `we`; `busy`=0 afterwards; a 9th pixel's bytes are discarded.
- **Abort:** abort asserted in PEND → no `we`, state IDLE; a new A5 then a pixel writes to address 0.
- **Reset mid-frame:** `rst` after 2 of 3 bytes → outputs return to reset values; A5 then a pixel writes to address 0 with the new data.
